// File: rtl/btn_ctrl.sv
// Push-button front end: per-button 2-FF sync + debounce, press-edge pulses,
// and an up/down auto-repeat FSM feeding the clock module's load interface.

module btn_db #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl
);
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC - 1);

    logic          s1, s2;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            lvl <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module btn_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 50_000_000,
    parameter int REPEAT_PER   = 10_000_000
) (
    input  logic       btn_ctrl_clk,
    input  logic       btn_ctrl_rst,
    input  logic       btn_ctrl_up,
    input  logic       btn_ctrl_down,
    input  logic       btn_ctrl_left,
    input  logic       btn_ctrl_right,
    input  logic       btn_ctrl_ctr,
    output logic [1:0] btn_ctrl_ud,
    output logic [1:0] btn_ctrl_lr,
    output logic       btn_ctrl_clr,
    output logic       btn_ctrl_held
);
    localparam int NUM_BTN = 5;
    localparam int B_UP = 4, B_DN = 3, B_LF = 2, B_RT = 1, B_CT = 0;
    localparam int TW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam logic [TW-1:0] DLY_LD = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_LD = TW'(REPEAT_PER - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [NUM_BTN-1:0] raw, lvl, lvl_d, press;
    state_t             state;
    logic               dir;      // 1 = up held, 0 = down held
    logic [TW-1:0]      timer;
    logic               dir_lvl, opp_lvl;

    assign raw = {btn_ctrl_up, btn_ctrl_down, btn_ctrl_left, btn_ctrl_right, btn_ctrl_ctr};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_db #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (btn_ctrl_clk),
            .rst_n (btn_ctrl_rst),
            .raw   (raw[i]),
            .lvl   (lvl[i])
        );
    end

    assign press   = lvl & ~lvl_d;
    assign dir_lvl = dir ? lvl[B_UP] : lvl[B_DN];
    assign opp_lvl = dir ? lvl[B_DN] : lvl[B_UP];

    always_ff @(posedge btn_ctrl_clk) begin
        if (!btn_ctrl_rst) begin
            lvl_d         <= '0;
            state         <= IDLE;
            dir           <= 1'b0;
            timer         <= '0;
            btn_ctrl_ud   <= 2'b00;
            btn_ctrl_lr   <= 2'b00;
            btn_ctrl_clr  <= 1'b0;
            btn_ctrl_held <= 1'b0;
        end else begin
            lvl_d        <= lvl;
            // an edge while the opposite button is down is dropped, not deferred
            btn_ctrl_lr  <= {press[B_LF] & ~lvl[B_RT], press[B_RT] & ~lvl[B_LF]};
            btn_ctrl_clr <= press[B_CT];
            btn_ctrl_ud  <= 2'b00;
            case (state)
                IDLE: begin
                    btn_ctrl_held <= 1'b0;
                    if (press[B_UP] && !lvl[B_DN]) begin
                        btn_ctrl_ud <= 2'b10;
                        dir         <= 1'b1;
                        timer       <= DLY_LD;
                        state       <= DELAY;
                    end else if (press[B_DN] && !lvl[B_UP]) begin
                        btn_ctrl_ud <= 2'b01;
                        dir         <= 1'b0;
                        timer       <= DLY_LD;
                        state       <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // release/conflict wins over a timer expiring on the same clock
                    if (!dir_lvl || opp_lvl) begin
                        state         <= IDLE;
                        btn_ctrl_held <= 1'b0;
                    end else if (timer == '0) begin
                        btn_ctrl_ud   <= dir ? 2'b10 : 2'b01;
                        timer         <= PER_LD;
                        state         <= REPEAT;
                        btn_ctrl_held <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
